// File: rtl/traffic_ctrl_param.sv
// rtl/traffic_ctrl_param.sv - car/pedestrian light controller with prescaler, phase timer, flash mode
module traffic_ctrl_param #(
  parameter int CNT_W       = 24,
  parameter int TB_DIV      = 12000000,
  parameter int TB_DIV_TEST = 4,
  parameter int T_GREEN     = 10,
  parameter int T_YELLOW    = 2,
  parameter int T_CLR       = 1,
  parameter int T_PED       = 8,
  parameter int T_RY        = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TESTMODE,
  input  logic       PED_REQ,
  input  logic       FLASH,
  output logic       G_CAR,
  output logic       Y_CAR,
  output logic       R_CAR,
  output logic       G_PEDES,
  output logic       R_PEDES,
  output logic       PED_WAIT,
  output logic [2:0] PHASE,
  output logic       TICK
);

  typedef enum logic [2:0] {
    S_GREEN   = 3'd0,
    S_YELLOW  = 3'd1,
    S_ALLRED1 = 3'd2,
    S_PEDGO   = 3'd3,
    S_ALLRED2 = 3'd4,
    S_REDYEL  = 3'd5,
    S_FLASHY  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] DIV_M1      = CNT_W'(TB_DIV - 1);
  localparam logic [CNT_W-1:0] DIV_TEST_M1 = CNT_W'(TB_DIV_TEST - 1);
  localparam logic [CNT_W-1:0] GREEN_M1    = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_M1   = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] CLR_M1      = CNT_W'(T_CLR - 1);
  localparam logic [CNT_W-1:0] PED_M1      = CNT_W'(T_PED - 1);
  localparam logic [CNT_W-1:0] RY_M1       = CNT_W'(T_RY - 1);

  state_t           state;
  state_t           succ;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] div_m1;
  logic [CNT_W-1:0] dur_m1;
  logic             tick;
  logic             req_q;
  logic             flash_q;

  // >= rather than == so a TESTMODE switch mid-count cannot skip past the wrap point
  assign div_m1 = TESTMODE ? DIV_TEST_M1 : DIV_M1;
  assign tick   = (cnt >= div_m1);

  always_comb begin
    succ   = S_ALLRED2;
    dur_m1 = CLR_M1;
    case (state)
      S_GREEN:   begin succ = S_YELLOW;  dur_m1 = GREEN_M1;  end
      S_YELLOW:  begin succ = S_ALLRED1; dur_m1 = YELLOW_M1; end
      S_ALLRED1: begin succ = S_PEDGO;   dur_m1 = CLR_M1;    end
      S_PEDGO:   begin succ = S_ALLRED2; dur_m1 = PED_M1;    end
      S_ALLRED2: begin succ = S_REDYEL;  dur_m1 = CLR_M1;    end
      S_REDYEL:  begin succ = S_GREEN;   dur_m1 = RY_M1;     end
      default:   begin succ = S_ALLRED2; dur_m1 = CLR_M1;    end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= S_ALLRED2;
      cnt     <= '0;
      timer   <= '0;
      req_q   <= 1'b0;
      flash_q <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (FLASH && state != S_FLASHY) begin
        state   <= S_FLASHY;
        timer   <= '0;
        flash_q <= 1'b0;
        req_q   <= 1'b0;
      end else if (state == S_FLASHY) begin
        req_q <= 1'b0;
        if (!FLASH) begin
          state <= S_ALLRED2;
          timer <= '0;
        end else if (tick) begin
          flash_q <= ~flash_q;
        end
      end else begin
        if (PED_REQ && state != S_PEDGO)
          req_q <= 1'b1;
        if (tick) begin
          if (timer == dur_m1) begin
            // green without a pending request holds with the timer parked at its limit
            if (!(state == S_GREEN && !req_q)) begin
              state <= succ;
              timer <= '0;
              if (succ == S_PEDGO)
                req_q <= 1'b0;
            end
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    G_CAR   = 1'b0;
    Y_CAR   = 1'b0;
    R_CAR   = 1'b0;
    G_PEDES = 1'b0;
    R_PEDES = 1'b0;
    case (state)
      S_GREEN:   begin G_CAR = 1'b1; R_PEDES = 1'b1; end
      S_YELLOW:  begin Y_CAR = 1'b1; R_PEDES = 1'b1; end
      S_ALLRED1: begin R_CAR = 1'b1; R_PEDES = 1'b1; end
      S_PEDGO:   begin R_CAR = 1'b1; G_PEDES = 1'b1; end
      S_ALLRED2: begin R_CAR = 1'b1; R_PEDES = 1'b1; end
      S_REDYEL:  begin R_CAR = 1'b1; Y_CAR = 1'b1; R_PEDES = 1'b1; end
      S_FLASHY:  begin Y_CAR = flash_q; end
      default:   begin R_CAR = 1'b1; R_PEDES = 1'b1; end
    endcase
  end

  assign PED_WAIT = req_q;
  assign PHASE    = state;
  assign TICK     = tick;

endmodule
